// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: show-ahead receive FIFO placed behind a UART receiver.
// Words arriving on DATA_VALID are queued and offered oldest-first on RD_DATA.
// A word that arrives while the FIFO is full, with no pop in the same cycle,
// is dropped and latches the sticky OVERFLOW flag.
module uart_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [DATA_WIDTH-1:0]    P_DATA,
    input  logic                     DATA_VALID,
    input  logic                     RD_READY,
    input  logic                     OVF_CLR,
    output logic [DATA_WIDTH-1:0]    RD_DATA,
    output logic                     RD_VALID,
    output logic [$clog2(DEPTH):0]   FIFO_COUNT,
    output logic                     FULL,
    output logic                     EMPTY,
    output logic                     OVERFLOW
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           count;
    logic                  ovf;
    logic                  pop;
    logic                  push;
    logic                  drop;

    // Transfer qualifiers; a full FIFO still takes a word when a pop frees a slot
    always_comb begin
        pop  = RD_VALID & RD_READY;
        push = DATA_VALID & (~FULL | pop);
        drop = DATA_VALID & FULL & ~pop;
    end

    // Storage is written on push only; contents need no reset
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= P_DATA;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Occupancy count: +1 on push only, -1 on pop only, else held
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow flag; a drop in the same cycle as a clear keeps it set
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end else if (OVF_CLR) begin
            ovf <= 1'b0;
        end
    end

    // Status and show-ahead read data, all derived from registered state
    always_comb begin
        FIFO_COUNT = count;
        FULL       = (count == DEPTH_CNT);
        EMPTY      = (count == '0);
        RD_VALID   = ~EMPTY;
        RD_DATA    = mem[rd_ptr];
        OVERFLOW   = ovf;
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed scenarios for uart_rx_fifo (DATA_WIDTH=8, DEPTH=8).
// Inputs change 1 ns after a rising edge; outputs are checked before the next edge.
module tb_uart_rx_fifo;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       RD_READY;
    logic       OVF_CLR;
    logic [7:0] RD_DATA;
    logic       RD_VALID;
    logic [3:0] FIFO_COUNT;
    logic       FULL;
    logic       EMPTY;
    logic       OVERFLOW;

    int pass_cnt  = 0;
    int total_cnt = 0;

    uart_rx_fifo #(
        .DATA_WIDTH(8),
        .DEPTH     (8)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .P_DATA    (P_DATA),
        .DATA_VALID(DATA_VALID),
        .RD_READY  (RD_READY),
        .OVF_CLR   (OVF_CLR),
        .RD_DATA   (RD_DATA),
        .RD_VALID  (RD_VALID),
        .FIFO_COUNT(FIFO_COUNT),
        .FULL      (FULL),
        .EMPTY     (EMPTY),
        .OVERFLOW  (OVERFLOW)
    );

    // Free-running 10 ns clock
    always #5 CLK = ~CLK;

    // Hard stop in case the sequence ever stalls
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        DATA_VALID = 1'b0;
        RD_READY   = 1'b0;
        OVF_CLR    = 1'b0;
        P_DATA     = 8'h00;
    endtask

    task automatic fill_1_to_8();
        for (int i = 1; i <= 8; i++) begin
            P_DATA     = 8'(i);
            DATA_VALID = 1'b1;
            step();
        end
        DATA_VALID = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        RST = 1'b1;
        #12;
        total_cnt++;
        if (EMPTY !== 1'b1) $display("FAIL reset_empty: got %b want 1", EMPTY); else pass_cnt++;
        total_cnt++;
        if (FULL !== 1'b0) $display("FAIL reset_full: got %b want 0", FULL); else pass_cnt++;
        total_cnt++;
        if (RD_VALID !== 1'b0) $display("FAIL reset_rd_valid: got %b want 0", RD_VALID); else pass_cnt++;
        total_cnt++;
        if (FIFO_COUNT !== 4'd0) $display("FAIL reset_count: got %0d want 0", FIFO_COUNT); else pass_cnt++;
        total_cnt++;
        if (OVERFLOW !== 1'b0) $display("FAIL reset_overflow: got %b want 0", OVERFLOW); else pass_cnt++;
        @(negedge CLK);
        RST = 1'b0;
        step();
    endtask

    task automatic test_single_push();
        P_DATA     = 8'hA5;
        DATA_VALID = 1'b1;
        step();
        DATA_VALID = 1'b0;
        total_cnt++;
        if (RD_VALID !== 1'b1) $display("FAIL single_rd_valid: got %b want 1", RD_VALID); else pass_cnt++;
        total_cnt++;
        if (RD_DATA !== 8'hA5) $display("FAIL single_rd_data: got %h want a5", RD_DATA); else pass_cnt++;
        total_cnt++;
        if (FIFO_COUNT !== 4'd1) $display("FAIL single_count: got %0d want 1", FIFO_COUNT); else pass_cnt++;
        total_cnt++;
        if (EMPTY !== 1'b0) $display("FAIL single_empty: got %b want 0", EMPTY); else pass_cnt++;
        RD_READY = 1'b1;
        step();
        RD_READY = 1'b0;
        total_cnt++;
        if (EMPTY !== 1'b1) $display("FAIL single_pop_empty: got %b want 1", EMPTY); else pass_cnt++;
    endtask

    task automatic test_overflow();
        fill_1_to_8();
        total_cnt++;
        if (FULL !== 1'b1) $display("FAIL ovf_full: got %b want 1", FULL); else pass_cnt++;
        total_cnt++;
        if (FIFO_COUNT !== 4'd8) $display("FAIL ovf_count_full: got %0d want 8", FIFO_COUNT); else pass_cnt++;
        total_cnt++;
        if (OVERFLOW !== 1'b0) $display("FAIL ovf_before_drop: got %b want 0", OVERFLOW); else pass_cnt++;
        P_DATA     = 8'h09;
        DATA_VALID = 1'b1;
        step();
        DATA_VALID = 1'b0;
        total_cnt++;
        if (OVERFLOW !== 1'b1) $display("FAIL ovf_set: got %b want 1", OVERFLOW); else pass_cnt++;
        total_cnt++;
        if (FIFO_COUNT !== 4'd8) $display("FAIL ovf_count_after_drop: got %0d want 8", FIFO_COUNT); else pass_cnt++;
        for (int i = 1; i <= 8; i++) begin
            total_cnt++;
            if (RD_DATA !== 8'(i) || RD_VALID !== 1'b1)
                $display("FAIL ovf_drain_%0d: got %h/%b want %h/1", i, RD_DATA, RD_VALID, 8'(i));
            else pass_cnt++;
            RD_READY = 1'b1;
            step();
        end
        RD_READY = 1'b0;
        total_cnt++;
        if (EMPTY !== 1'b1) $display("FAIL ovf_drained_empty: got %b want 1 (0x09 leaked)", EMPTY); else pass_cnt++;
        total_cnt++;
        if (OVERFLOW !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", OVERFLOW); else pass_cnt++;
        OVF_CLR = 1'b1;
        step();
        OVF_CLR = 1'b0;
        total_cnt++;
        if (OVERFLOW !== 1'b0) $display("FAIL ovf_cleared: got %b want 0", OVERFLOW); else pass_cnt++;
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp_q [8];
        exp_q = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h55};
        fill_1_to_8();
        total_cnt++;
        if (RD_DATA !== 8'h01) $display("FAIL fpp_head: got %h want 01", RD_DATA); else pass_cnt++;
        P_DATA     = 8'h55;
        DATA_VALID = 1'b1;
        RD_READY   = 1'b1;
        step();
        DATA_VALID = 1'b0;
        RD_READY   = 1'b0;
        total_cnt++;
        if (FIFO_COUNT !== 4'd8) $display("FAIL fpp_count: got %0d want 8", FIFO_COUNT); else pass_cnt++;
        total_cnt++;
        if (OVERFLOW !== 1'b0) $display("FAIL fpp_overflow: got %b want 0", OVERFLOW); else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            total_cnt++;
            if (RD_DATA !== exp_q[i] || RD_VALID !== 1'b1)
                $display("FAIL fpp_drain_%0d: got %h/%b want %h/1", i, RD_DATA, RD_VALID, exp_q[i]);
            else pass_cnt++;
            RD_READY = 1'b1;
            step();
        end
        RD_READY = 1'b0;
        total_cnt++;
        if (EMPTY !== 1'b1) $display("FAIL fpp_empty: got %b want 1", EMPTY); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        // First cycle pops an empty FIFO (no effect); the word shows up next cycle
        for (int i = 0; i < 20; i++) begin
            P_DATA     = 8'(i);
            DATA_VALID = 1'b1;
            RD_READY   = 1'b1;
            if (i > 0) begin
                total_cnt++;
                if (RD_DATA !== 8'(i - 1) || RD_VALID !== 1'b1)
                    $display("FAIL b2b_data_%0d: got %h/%b want %h/1", i - 1, RD_DATA, RD_VALID, 8'(i - 1));
                else pass_cnt++;
            end
            step();
            total_cnt++;
            if (FIFO_COUNT !== 4'd1) $display("FAIL b2b_count_%0d: got %0d want 1", i, FIFO_COUNT); else pass_cnt++;
        end
        DATA_VALID = 1'b0;
        total_cnt++;
        if (RD_DATA !== 8'h13) $display("FAIL b2b_last: got %h want 13", RD_DATA); else pass_cnt++;
        step();
        RD_READY = 1'b0;
        total_cnt++;
        if (EMPTY !== 1'b1) $display("FAIL b2b_empty: got %b want 1", EMPTY); else pass_cnt++;
        total_cnt++;
        if (OVERFLOW !== 1'b0) $display("FAIL b2b_overflow: got %b want 0", OVERFLOW); else pass_cnt++;
    endtask

    task automatic test_ovf_clr_race();
        fill_1_to_8();
        P_DATA     = 8'hEE;
        DATA_VALID = 1'b1;
        step();
        total_cnt++;
        if (OVERFLOW !== 1'b1) $display("FAIL race_set: got %b want 1", OVERFLOW); else pass_cnt++;
        OVF_CLR = 1'b1;
        step();
        DATA_VALID = 1'b0;
        total_cnt++;
        if (OVERFLOW !== 1'b1) $display("FAIL race_set_wins: got %b want 1", OVERFLOW); else pass_cnt++;
        step();
        OVF_CLR = 1'b0;
        total_cnt++;
        if (OVERFLOW !== 1'b0) $display("FAIL race_clear: got %b want 0", OVERFLOW); else pass_cnt++;
        total_cnt++;
        if (FIFO_COUNT !== 4'd8 || RD_DATA !== 8'h01)
            $display("FAIL race_contents: got %0d/%h want 8/01", FIFO_COUNT, RD_DATA);
        else pass_cnt++;
        RD_READY = 1'b1;
        for (int i = 0; i < 8; i++) step();
        RD_READY = 1'b0;
        total_cnt++;
        if (EMPTY !== 1'b1) $display("FAIL race_drain_empty: got %b want 1", EMPTY); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) begin
            P_DATA     = 8'(8'h10 + i);
            DATA_VALID = 1'b1;
            step();
        end
        DATA_VALID = 1'b0;
        total_cnt++;
        if (FIFO_COUNT !== 4'd5) $display("FAIL arst_count_before: got %0d want 5", FIFO_COUNT); else pass_cnt++;
        #2;
        RST = 1'b1;
        #1;
        total_cnt++;
        if (EMPTY !== 1'b1 || RD_VALID !== 1'b0 || FIFO_COUNT !== 4'd0)
            $display("FAIL arst_immediate: got empty=%b valid=%b count=%0d want 1/0/0", EMPTY, RD_VALID, FIFO_COUNT);
        else pass_cnt++;
        #1;
        RST = 1'b0;
        P_DATA     = 8'h3C;
        DATA_VALID = 1'b1;
        step();
        DATA_VALID = 1'b0;
        total_cnt++;
        if (RD_DATA !== 8'h3C || FIFO_COUNT !== 4'd1)
            $display("FAIL arst_first_push: got %h/%0d want 3c/1", RD_DATA, FIFO_COUNT);
        else pass_cnt++;
        RD_READY = 1'b1;
        step();
        RD_READY = 1'b0;
        total_cnt++;
        if (EMPTY !== 1'b1) $display("FAIL arst_only_word: got %b want 1", EMPTY); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_overflow();
        test_full_push_pop();
        test_back_to_back();
        test_ovf_clr_race();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of the received frame data word.
REQ-002 SHALL have parameter DEPTH, default 8, number of storage entries; a power of two, at least 2.
REQ-003 SHALL have port CLK  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port RST  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port P_DATA  input  DATA_WIDTH  received data word from the UART receiver.
REQ-006 SHALL have port DATA_VALID  input  1  write strobe; each cycle high is one write request of P_DATA.
REQ-007 SHALL have port RD_READY  input  1  consumer accepts RD_DATA this cycle.
REQ-008 SHALL have port OVF_CLR  input  1  clears the OVERFLOW flag.
REQ-009 SHALL have port RD_DATA  output  DATA_WIDTH  oldest stored word (show-ahead).
REQ-010 SHALL have port RD_VALID  output  1  RD_DATA holds a valid word.
REQ-011 SHALL have port FIFO_COUNT  output  log2(DEPTH)+1  number of stored words, 0..DEPTH.
REQ-012 SHALL have port FULL  output  1  FIFO_COUNT equals DEPTH.
REQ-013 SHALL have port EMPTY  output  1  FIFO_COUNT equals 0.
REQ-014 SHALL have port OVERFLOW  output  1  sticky; at least one word has been dropped.

Function
REQ-015 The block SHALL define pop as RD_VALID and RD_READY in the same cycle, and push as DATA_VALID and (not FULL or pop).
REQ-016 On push, the block SHALL store P_DATA at the write pointer and advance the write pointer by 1, modulo DEPTH.
REQ-017 On pop, the block SHALL advance the read pointer by 1, modulo DEPTH.
REQ-018 RD_DATA SHALL be the entry at the read pointer, with no read latency.
REQ-019 RD_DATA SHALL be don't-care while RD_VALID is 0.
REQ-020 RD_VALID SHALL equal not EMPTY.
REQ-021 A word pushed at edge N SHALL appear on RD_DATA with RD_VALID=1 after edge N when the FIFO was empty.
REQ-022 FIFO_COUNT SHALL be registered and SHALL change as follows: +1 on push only, -1 on pop only, unchanged on both or neither.
REQ-023 FULL and EMPTY SHALL be derived from FIFO_COUNT and consistent with it in every cycle.
REQ-024 When full with a simultaneous pop, the block SHALL accept DATA_VALID; FIFO_COUNT stays DEPTH and no overflow is flagged.
REQ-025 A pop SHALL have no effect while the FIFO is empty, including when RD_READY=1 and DATA_VALID=1 in the same cycle; the pushed word becomes visible the next cycle.
REQ-026 When DATA_VALID=1, FULL=1 and there is no pop, the block SHALL drop the word, leave storage, pointers and count unchanged, and set OVERFLOW at the next edge.
REQ-027 OVERFLOW SHALL remain 1 until OVF_CLR=1 is sampled.
REQ-028 If a set condition and OVF_CLR occur in the same cycle, set SHALL win.
REQ-029 Pointer wrap from DEPTH-1 to 0 SHALL be seamless, with no lost or duplicated entry.
REQ-030 The block SHALL hold no other state machine beyond the pointers, count and flag, and SHALL sustain one push and one pop per cycle.

Reset
REQ-031 While RST=1, the block SHALL asynchronously force: pointers=0, FIFO_COUNT=0, EMPTY=1, FULL=0, RD_VALID=0, OVERFLOW=0.
REQ-032 Storage contents SHALL need no reset.
REQ-033 A reset asserted mid-operation SHALL discard all stored words immediately, without waiting for a clock edge.
REQ-034 The first push after reset release SHALL land at entry 0.

Verification
REQ-035 Scenario 1: after reset, push 0xA5 with one DATA_VALID pulse, RD_READY=0 -> next cycle RD_VALID=1, RD_DATA=0xA5, FIFO_COUNT=1, EMPTY=0.
REQ-036 Scenario 2: push 0x01..0x08 (DEPTH=8), RD_READY=0 -> FULL=1, FIFO_COUNT=8; then push 0x09 -> OVERFLOW=1, count stays 8; drain -> 0x01..0x08 in order, 0x09 never appears.
REQ-037 Scenario 3: FIFO full, DATA_VALID=1 with 0x55 and RD_READY=1 in the same cycle -> 0x01 popped, 0x55 stored, FIFO_COUNT=8, OVERFLOW unchanged; drain ends with 0x55.
REQ-038 Scenario 4: continuous push 0x00..0x13 with RD_READY=1 every cycle -> every word read out exactly once, in order, across pointer wrap; FIFO_COUNT never exceeds 1; OVERFLOW=0.
REQ-039 Scenario 5: OVERFLOW=1, with a drop condition and OVF_CLR=1 in the same cycle -> OVERFLOW stays 1; then OVF_CLR=1 alone -> OVERFLOW=0 next cycle.
REQ-040 Scenario 6: 5 words stored, RST pulsed between clock edges -> EMPTY=1, RD_VALID=0, FIFO_COUNT=0 immediately; next push 0x3C is read back as the only word.
